// File: rtl/mem_arbiter.sv
// mem_arbiter: burst-limited round-robin arbiter sharing one 1-cycle-latency memory among NumPorts requesters
module mem_arbiter #(
  parameter int NumPorts = 2,
  parameter int Width    = 32,
  parameter int Aw       = 15,
  parameter int MaxBurst = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumPorts-1:0]       req_valid_i,
  output logic [NumPorts-1:0]       req_ready_o,
  input  logic [NumPorts-1:0]       req_write_i,
  input  logic [NumPorts*Aw-1:0]    req_addr_i,
  input  logic [NumPorts*Width-1:0] req_wdata_i,
  input  logic [NumPorts*Width-1:0] req_wmask_i,
  output logic [NumPorts-1:0]       rsp_valid_o,
  output logic [Width-1:0]          rsp_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_write_o,
  output logic [Aw-1:0]             mem_addr_o,
  output logic [Width-1:0]          mem_wdata_o,
  output logic [Width-1:0]          mem_wmask_o,
  input  logic [Width-1:0]          mem_rdata_i
);
  localparam int Pw = $clog2(NumPorts);
  localparam logic [3:0] MaxB = 4'(MaxBurst);
  logic [Pw-1:0] owner_q, owner_d, rsp_port_q, gnt_idx;
  logic [3:0] burst_q, burst_d;
  logic rsp_vld_q, rsp_write_q, gnt;
  always_comb begin
    gnt = |req_valid_i;
    gnt_idx = owner_q;
    for (int i = NumPorts; i >= 1; i--)
      if (req_valid_i[(int'(owner_q) + i) % NumPorts]) gnt_idx = Pw'((int'(owner_q) + i) % NumPorts);
    if (req_valid_i[owner_q] && burst_q < MaxB) gnt_idx = owner_q;
  end
  assign req_ready_o = gnt ? (NumPorts'(1) << gnt_idx) : '0;
  assign mem_req_o   = gnt;
  assign mem_write_o = gnt & req_write_i[gnt_idx];
  assign mem_addr_o  = gnt ? req_addr_i[int'(gnt_idx)*Aw +: Aw] : '0;
  assign mem_wdata_o = gnt ? req_wdata_i[int'(gnt_idx)*Width +: Width] : '0;
  assign mem_wmask_o = gnt ? req_wmask_i[int'(gnt_idx)*Width +: Width] : '0;
  assign owner_d = gnt ? gnt_idx : owner_q;
  assign burst_d = !gnt ? 4'd0 : gnt_idx != owner_q ? 4'd1 : burst_q == 4'hf ? 4'hf : burst_q + 4'd1;
  assign rsp_valid_o = rsp_vld_q ? (NumPorts'(1) << rsp_port_q) : '0;
  assign rsp_rdata_o = (rsp_vld_q & ~rsp_write_q) ? mem_rdata_i : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q     <= '0;
      burst_q     <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_port_q  <= '0;
      rsp_write_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      rsp_vld_q   <= gnt;
      rsp_port_q  <= gnt ? gnt_idx : rsp_port_q;
      rsp_write_q <= gnt ? mem_write_o : rsp_write_q;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven scoreboard bench for mem_arbiter (2-port burst and 3-port round-robin instances)
module tb_mem_arbiter;
  typedef struct {
    logic       rst;
    logic [1:0] v2;
    logic [1:0] w2;
    logic [1:0] g2;
    logic [2:0] v3;
    logic [2:0] g3;
  } vec_t;
  typedef struct {
    logic [1:0]  rsp2;
    logic [31:0] data2;
    logic [2:0]  rsp3;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] valid2 = '0, write2 = '0, ready2, rspv2;
  logic [14:0] pa [2];
  logic [31:0] pd [2];
  logic [31:0] pm [2];
  logic [29:0] addr2;
  logic [63:0] wdata2, wmask2;
  logic [31:0] rdata2, mwd2, mwm2, mrd2;
  logic mreq2, mwr2;
  logic [14:0] maddr2;
  logic [2:0] valid3 = '0, ready3, rspv3;
  logic [31:0] rdata3, mwd3, mwm3;
  logic mreq3, mwr3;
  logic [14:0] maddr3;
  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];
  sb_t sb [$];
  vec_t tbl [$];
  int pass_n = 0;
  int tot_n = 0;
  always #5 clk = ~clk;
  assign addr2  = {pa[1], pa[0]};
  assign wdata2 = {pd[1], pd[0]};
  assign wmask2 = {pm[1], pm[0]};
  mem_arbiter #(.NumPorts(2), .Width(32), .Aw(15), .MaxBurst(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid2), .req_ready_o(ready2), .req_write_i(write2),
    .req_addr_i(addr2), .req_wdata_i(wdata2), .req_wmask_i(wmask2),
    .rsp_valid_o(rspv2), .rsp_rdata_o(rdata2),
    .mem_req_o(mreq2), .mem_write_o(mwr2), .mem_addr_o(maddr2),
    .mem_wdata_o(mwd2), .mem_wmask_o(mwm2), .mem_rdata_i(mrd2)
  );
  mem_arbiter #(.NumPorts(3), .Width(32), .Aw(15), .MaxBurst(1)) u3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid3), .req_ready_o(ready3), .req_write_i(3'b000),
    .req_addr_i(45'd0), .req_wdata_i(96'd0), .req_wmask_i(96'd0),
    .rsp_valid_o(rspv3), .rsp_rdata_o(rdata3),
    .mem_req_o(mreq3), .mem_write_o(mwr3), .mem_addr_o(maddr3),
    .mem_wdata_o(mwd3), .mem_wmask_o(mwm3), .mem_rdata_i(32'd0)
  );
  function automatic logic [31:0] init_val(input int i);
    return i == 16 ? 32'hDEADBEEF : i == 4 ? 32'hAAAAAAAA : (32'hC0DE0000 | 32'(i));
  endfunction
  always @(posedge clk) begin
    mrd2 <= '0;
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mreq2) begin
      if (mwr2) mem[maddr2[7:0]] <= (mem[maddr2[7:0]] & ~mwm2) | (mwd2 & mwm2);
      else mrd2 <= mem[maddr2[7:0]];
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    valid2 = '0;
    write2 = '0;
    valid3 = '0;
    sb.delete();
    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
    @(negedge clk);
    chk("rst_ready2", ready2, 0);
    chk("rst_rspv2", rspv2, 0);
    chk("rst_rdata2", rdata2, 0);
    chk("rst_mreq2", mreq2, 0);
    chk("rst_rspv3", rspv3, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic step(input vec_t t, input int n);
    sb_t e;
    int gp;
    valid2 = t.v2;
    write2 = t.w2;
    valid3 = t.v3;
    #1;
    chk($sformatf("gnt2[%0d]", n), ready2, t.g2);
    chk($sformatf("gnt3[%0d]", n), ready3, t.g3);
    chk($sformatf("mreq2[%0d]", n), mreq2, |t.g2);
    e = '{rsp2: t.g2, data2: 32'd0, rsp3: t.g3};
    if (t.g2 != 2'b00) begin
      gp = t.g2[1] ? 1 : 0;
      chk($sformatf("maddr2[%0d]", n), maddr2, pa[gp]);
      if (t.w2[gp]) exp_mem[pa[gp][7:0]] = (exp_mem[pa[gp][7:0]] & ~pm[gp]) | (pd[gp] & pm[gp]);
      else e.data2 = exp_mem[pa[gp][7:0]];
    end
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("rsp2[%0d]", n), rspv2, e.rsp2);
    chk($sformatf("rdata2[%0d]", n), rdata2, e.data2);
    chk($sformatf("rsp3[%0d]", n), rspv3, e.rsp3);
  endtask
  function automatic vec_t mk(input logic r, input logic [1:0] v2, input logic [1:0] w2,
                              input logic [1:0] g2, input logic [2:0] v3, input logic [2:0] g3);
    return '{rst: r, v2: v2, w2: w2, g2: g2, v3: v3, g3: g3};
  endfunction
  initial begin
    pa[0] = 15'h0004;
    pa[1] = 15'h0010;
    pd[0] = 32'h12345678;
    pd[1] = 32'h0;
    pm[0] = 32'hFFFF0000;
    pm[1] = 32'h0;
    tbl.push_back(mk(1, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b01, 2'b01, 2'b01, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    tbl.push_back(mk(1, 2'b11, 2'b00, 2'b01, 3'b000, 3'b000));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 3'b000, 3'b000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 2'b11, 2'b00, 2'b10, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 2'b01, 2'b00, 2'b01, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 2'b11, 2'b00, 2'b01, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b11, 2'b00, 2'b10, 3'b000, 3'b000));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b111, 3'b001));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b111, 3'b010));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b111, 3'b100));
    end
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b101, 3'b001));
      tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b101, 3'b100));
    end
    tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000));
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i], i);
    end
    valid2 = 2'b10;
    write2 = 2'b00;
    #1;
    chk("mr_gnt", ready2, 2'b10);
    @(posedge clk);
    #1;
    chk("mr_rsp_live", rspv2, 2'b10);
    chk("mr_rdata_live", rdata2, 32'hDEADBEEF);
    rst_n = 1'b0;
    valid2 = 2'b00;
    #1;
    chk("mr_rsp_drop", rspv2, 0);
    chk("mr_rdata_drop", rdata2, 0);
    chk("mr_mreq_drop", mreq2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    step(mk(0, 2'b11, 2'b00, 2'b01, 3'b000, 3'b000), 100);
    step(mk(0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000), 101);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
